// File: rtl/sc_rng_pkg.sv
// Shared types and helpers for the random-number scheduler.
// State encoding, requester count and stir counter sizing.
package sc_rng_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    STIR,
    CAPTURE,
    WAITREG,
    DELIVER
  } state_t;

  localparam int NUM_REQ = 2;

  function automatic int stirWidth(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sc_rng_rr_arbiter2.sv
// Two-way round-robin pick with a registered priority pointer.
// The pointer moves past the requester that just finished.
module sc_rng_rr_arbiter2
  import sc_rng_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  input  logic               doneIdx,
  output logic [NUM_REQ-1:0] pick
);

  logic ptr;

  always_comb begin
    pick = '0;
    if (ptr) begin
      if (req[1])      pick = 2'b10;
      else if (req[0]) pick = 2'b01;
    end else begin
      if (req[0])      pick = 2'b01;
      else if (req[1]) pick = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr <= 1'b0;
    else if (done) ptr <= ~doneIdx;
  end

endmodule

// File: rtl/sc_rng_scheduler.sv
// Arbitrates two requesters onto the LFSR/output-register datapath,
// serialising seed loads and enforcing stir time between captures.
module sc_rng_scheduler
  import sc_rng_pkg::*;
#(
  parameter int DATAWIDTH   = 8,
  parameter int STIR_CYCLES = 8
) (
  input  logic                 SC_RNGSCHED_CLOCK_50,
  input  logic                 SC_RNGSCHED_RESET_InLow,
  input  logic                 SC_RNGSCHED_seedreq_InLow,
  input  logic [NUM_REQ-1:0]   SC_RNGSCHED_req_InBUS,
  input  logic [DATAWIDTH-1:0] SC_RNGSCHED_data_InBUS,
  output logic                 SC_RNGSCHED_loadseed_OutLow,
  output logic                 SC_RNGSCHED_loadrand_OutLow,
  output logic [NUM_REQ-1:0]   SC_RNGSCHED_grant_OutBUS,
  output logic                 SC_RNGSCHED_valid_OutHigh,
  output logic [DATAWIDTH-1:0] SC_RNGSCHED_data_OutBUS,
  output logic                 SC_RNGSCHED_busy_OutHigh
);

  localparam int CW = stirWidth(STIR_CYCLES);
  localparam logic [CW-1:0] STIR_MAX = CW'(STIR_CYCLES);

  logic clk;
  logic rst_n;
  logic [NUM_REQ-1:0] req;

  assign clk   = SC_RNGSCHED_CLOCK_50;
  assign rst_n = SC_RNGSCHED_RESET_InLow;
  assign req   = SC_RNGSCHED_req_InBUS;

  state_t state;
  state_t stateNext;

  logic               seedPrev;
  logic               seedPending;
  logic               seedFall;
  logic [CW-1:0]      stirCnt;
  logic [NUM_REQ-1:0] grantQ;
  logic [NUM_REQ-1:0] pick;
  logic [DATAWIDTH-1:0] dataQ;
  logic               reqGranted;
  logic               done;

  assign seedFall   = seedPrev & ~SC_RNGSCHED_seedreq_InLow;
  assign reqGranted = |(req & grantQ);
  assign done       = (state == DELIVER) && !reqGranted;

  sc_rng_rr_arbiter2 uArb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .doneIdx (grantQ[1]),
    .pick    (pick)
  );

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: begin
        if (seedPending)  stateNext = SEED;
        else if (|req)    stateNext = STIR;
      end
      SEED:    stateNext = IDLE;
      STIR: begin
        if (stirCnt == STIR_MAX) stateNext = CAPTURE;
      end
      CAPTURE: stateNext = WAITREG;
      WAITREG: stateNext = DELIVER;
      DELIVER: begin
        if (!reqGranted) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      seedPrev    <= 1'b1;
      seedPending <= 1'b0;
      stirCnt     <= '0;
      grantQ      <= '0;
      dataQ       <= '0;
    end else begin
      state       <= stateNext;
      seedPrev    <= SC_RNGSCHED_seedreq_InLow;
      seedPending <= (seedPending & (state != SEED)) | seedFall;
      // Stir time restarts whenever the generator is reseeded or sampled
      if (state == SEED || state == CAPTURE) stirCnt <= '0;
      else if (stirCnt != STIR_MAX)          stirCnt <= stirCnt + CW'(1);
      if (state == IDLE && stateNext == STIR) grantQ <= pick;
      else if (done)                          grantQ <= '0;
      if (state == WAITREG) dataQ <= SC_RNGSCHED_data_InBUS;
    end
  end

  assign SC_RNGSCHED_loadseed_OutLow = (state != SEED);
  assign SC_RNGSCHED_loadrand_OutLow = (state != CAPTURE);
  assign SC_RNGSCHED_grant_OutBUS    = grantQ;
  assign SC_RNGSCHED_valid_OutHigh   = (state == DELIVER) && reqGranted;
  assign SC_RNGSCHED_data_OutBUS     = dataQ;
  assign SC_RNGSCHED_busy_OutHigh    = (state != IDLE);

endmodule

// File: tb/tb_sc_rng_scheduler.sv
// Directed bench for sc_rng_scheduler.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_sc_rng_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       seedreq = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] dIn = 8'h00;

  logic       loadSeed;
  logic       loadRand;
  logic [1:0] grant;
  logic       valid;
  logic [7:0] dOut;
  logic       busy;

  int nChecks = 0;
  int nFail = 0;

  sc_rng_scheduler #(
    .DATAWIDTH   (8),
    .STIR_CYCLES (8)
  ) dut (
    .SC_RNGSCHED_CLOCK_50        (clk),
    .SC_RNGSCHED_RESET_InLow     (rst_n),
    .SC_RNGSCHED_seedreq_InLow   (seedreq),
    .SC_RNGSCHED_req_InBUS       (req),
    .SC_RNGSCHED_data_InBUS      (dIn),
    .SC_RNGSCHED_loadseed_OutLow (loadSeed),
    .SC_RNGSCHED_loadrand_OutLow (loadRand),
    .SC_RNGSCHED_grant_OutBUS    (grant),
    .SC_RNGSCHED_valid_OutHigh   (valid),
    .SC_RNGSCHED_data_OutBUS     (dOut),
    .SC_RNGSCHED_busy_OutHigh    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic doReset();
    rst_n = 1'b0;
    req = 2'b00;
    seedreq = 1'b1;
    dIn = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    nChecks++;
    if (loadSeed !== 1'b1) begin nFail++; $display("FAIL rst_loadseed got %b want 1", loadSeed); end
    nChecks++;
    if (loadRand !== 1'b1) begin nFail++; $display("FAIL rst_loadrand got %b want 1", loadRand); end
    nChecks++;
    if (grant !== 2'b00) begin nFail++; $display("FAIL rst_grant got %b want 00", grant); end
    nChecks++;
    if (valid !== 1'b0) begin nFail++; $display("FAIL rst_valid got %b want 0", valid); end
    nChecks++;
    if (dOut !== 8'h00) begin nFail++; $display("FAIL rst_data got %h want 00", dOut); end
    nChecks++;
    if (busy !== 1'b0) begin nFail++; $display("FAIL rst_busy got %b want 0", busy); end
    doReset();
  endtask

  task automatic test_single();
    doReset();
    req = 2'b01;
    @(negedge clk);
    nChecks++;
    if (loadRand !== 1'b1 || grant !== 2'b01 || busy !== 1'b1 || valid !== 1'b0) begin
      nFail++;
      $display("FAIL single_c1 got lr=%b g=%b b=%b v=%b want 1 01 1 0", loadRand, grant, busy, valid);
    end
    @(negedge clk);
    nChecks++;
    if (loadRand !== 1'b0 || loadSeed !== 1'b1) begin
      nFail++;
      $display("FAIL single_c2 got lr=%b ls=%b want 0 1", loadRand, loadSeed);
    end
    @(negedge clk);
    nChecks++;
    if (loadRand !== 1'b1 || valid !== 1'b0 || dOut !== 8'h00) begin
      nFail++;
      $display("FAIL single_c3 got lr=%b v=%b d=%h want 1 0 00", loadRand, valid, dOut);
    end
    dIn = 8'hA5;
    @(negedge clk);
    nChecks++;
    if (valid !== 1'b1 || dOut !== 8'hA5 || grant !== 2'b01) begin
      nFail++;
      $display("FAIL single_c4 got v=%b d=%h g=%b want 1 a5 01", valid, dOut, grant);
    end
    req = 2'b00;
    #1;
    nChecks++;
    if (valid !== 1'b0) begin nFail++; $display("FAIL single_drop got v=%b want 0", valid); end
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || grant !== 2'b00 || dOut !== 8'hA5) begin
      nFail++;
      $display("FAIL single_idle got b=%b g=%b d=%h want 0 00 a5", busy, grant, dOut);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    req = 2'b01;
    dIn = 8'h77;
    repeat (4) @(negedge clk);
    nChecks++;
    if (valid !== 1'b1) begin nFail++; $display("FAIL arst_pre got v=%b want 1", valid); end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (valid !== 1'b0 || grant !== 2'b00 || busy !== 1'b0 || dOut !== 8'h00 ||
        loadSeed !== 1'b1 || loadRand !== 1'b1) begin
      nFail++;
      $display("FAIL arst got v=%b g=%b b=%b d=%h ls=%b lr=%b want 0 00 0 00 1 1",
               valid, grant, busy, dOut, loadSeed, loadRand);
    end
    doReset();
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    logic [7:0] got[$];
    bit reraise;
    reraise = 1'b0;
    doReset();
    req = 2'b01;
    dIn = 8'h5A;
    for (int c = 1; c <= 80 && got.size() < 2; c++) begin
      @(negedge clk);
      if (reraise) begin
        req = 2'b01;
        reraise = 1'b0;
      end
      if (!loadRand) pulses.push_back(c);
      if (valid) begin
        got.push_back(dOut);
        req = 2'b00;
        dIn = 8'h3C;
        reraise = (got.size() < 2);
      end
    end
    nChecks++;
    if (got.size() != 2 || pulses.size() != 2) begin
      nFail++;
      $display("FAIL b2b_count got %0d/%0d want 2/2", got.size(), pulses.size());
    end else begin
      nChecks++;
      if (pulses[1] - pulses[0] != 10) begin
        nFail++;
        $display("FAIL b2b_gap got %0d want 10", pulses[1] - pulses[0]);
      end
      nChecks++;
      if (got[0] !== 8'h5A || got[1] !== 8'h3C) begin
        nFail++;
        $display("FAIL b2b_data got %h %h want 5a 3c", got[0], got[1]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g[$];
    logic [1:0] gnt;
    int c;
    c = 0;
    doReset();
    req = 2'b11;
    while (g.size() < 3 && c < 200) begin
      @(negedge clk);
      c++;
      if (valid) begin
        gnt = grant;
        g.push_back(gnt);
        @(negedge clk);
        nChecks++;
        if (valid !== 1'b1 || grant !== gnt) begin
          nFail++;
          $display("FAIL rr_hold got v=%b g=%b want 1 %b", valid, grant, gnt);
        end
        req = 2'b11 & ~gnt;
        @(negedge clk);
        nChecks++;
        if (grant !== 2'b00) begin
          nFail++;
          $display("FAIL rr_release got %b want 00", grant);
        end
        req = 2'b11;
      end
    end
    nChecks++;
    if (g.size() != 3) begin
      nFail++;
      $display("FAIL rr_count got %0d want 3", g.size());
    end else begin
      nChecks++;
      if (g[0] !== 2'b01 || g[1] !== 2'b10 || g[2] !== 2'b01) begin
        nFail++;
        $display("FAIL rr_seq got %b %b %b want 01 10 01", g[0], g[1], g[2]);
      end
    end
    req = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_seed_during_deliver();
    int c;
    int gap;
    doReset();
    req = 2'b11;
    dIn = 8'hC3;
    c = 0;
    while (!valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    nChecks++;
    if (valid !== 1'b1 || grant !== 2'b01) begin
      nFail++;
      $display("FAIL sd_first got v=%b g=%b want 1 01", valid, grant);
    end
    seedreq = 1'b0;
    @(negedge clk);
    nChecks++;
    if (valid !== 1'b1 || loadSeed !== 1'b1) begin
      nFail++;
      $display("FAIL sd_hold got v=%b ls=%b want 1 1", valid, loadSeed);
    end
    req = 2'b10;
    @(negedge clk);
    nChecks++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      nFail++;
      $display("FAIL sd_idle1 got b=%b g=%b want 0 00", busy, grant);
    end
    @(negedge clk);
    nChecks++;
    if (loadSeed !== 1'b0 || loadRand !== 1'b1 || busy !== 1'b1 || grant !== 2'b00) begin
      nFail++;
      $display("FAIL sd_seed got ls=%b lr=%b b=%b g=%b want 0 1 1 00",
               loadSeed, loadRand, busy, grant);
    end
    @(negedge clk);
    nChecks++;
    if (loadSeed !== 1'b1 || busy !== 1'b0) begin
      nFail++;
      $display("FAIL sd_idle2 got ls=%b b=%b want 1 0", loadSeed, busy);
    end
    @(negedge clk);
    nChecks++;
    if (grant !== 2'b10 || busy !== 1'b1) begin
      nFail++;
      $display("FAIL sd_grant got g=%b b=%b want 10 1", grant, busy);
    end
    gap = 2;
    while (loadRand && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    nChecks++;
    if (gap != 10) begin
      nFail++;
      $display("FAIL sd_gap got %0d want 10", gap);
    end
    repeat (2) @(negedge clk);
    nChecks++;
    if (valid !== 1'b1 || dOut !== 8'hC3 || grant !== 2'b10) begin
      nFail++;
      $display("FAIL sd_deliver got v=%b d=%h g=%b want 1 c3 10", valid, dOut, grant);
    end
    req = 2'b00;
    seedreq = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_seed_hold();
    int seeds;
    int rands;
    seeds = 0;
    rands = 0;
    doReset();
    seedreq = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!loadSeed) seeds++;
      if (!loadRand) rands++;
    end
    seedreq = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!loadSeed) seeds++;
      if (!loadRand) rands++;
    end
    nChecks++;
    if (seeds != 1) begin nFail++; $display("FAIL hold_seeds got %0d want 1", seeds); end
    nChecks++;
    if (rands != 0) begin nFail++; $display("FAIL hold_rands got %0d want 0", rands); end
    nChecks++;
    if (busy !== 1'b0) begin nFail++; $display("FAIL hold_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_async_reset();
    test_back_to_back();
    test_round_robin();
    test_seed_during_deliver();
    test_seed_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/sc_rng_scheduler.md
Name: sc_rng_scheduler

Overview:
- Controller for the pseudo-random datapath: the LFSR generator with seed load, feeding the general output register with an active-low load.
- Shares the generator between two requesters using round-robin arbitration.
- Serialises seed loads against samples and enforces a minimum number of LFSR stir cycles between captures, so consecutive bytes are decorrelated.
- Returns each captured byte to the granted requester over a valid/req handshake.

Parameters:
- DATAWIDTH, 8, width of random data in and out.
- STIR_CYCLES, 8, minimum clock cycles between a seed/capture pulse and the next capture; 0 means no wait.

Ports:
- SC_RNGSCHED_CLOCK_50  in  1  system clock.
- SC_RNGSCHED_RESET_InLow  in  1  asynchronous, active-low reset.
- SC_RNGSCHED_seedreq_InLow  in  1  debounced seed button, active-low level; falling edge detected internally.
- SC_RNGSCHED_req_InBUS  in  2  per-requester sample request, active-high, held until delivery.
- SC_RNGSCHED_data_InBUS  in  DATAWIDTH  output of the general register.
- SC_RNGSCHED_loadseed_OutLow  out  1  one-cycle active-low seed-load strobe to the generator.
- SC_RNGSCHED_loadrand_OutLow  out  1  one-cycle active-low load strobe to the general register.
- SC_RNGSCHED_grant_OutBUS  out  2  one-hot grant; zero when idle.
- SC_RNGSCHED_valid_OutHigh  out  1  data_OutBUS valid for the granted requester.
- SC_RNGSCHED_data_OutBUS  out  DATAWIDTH  registered delivered byte.
- SC_RNGSCHED_busy_OutHigh  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous, active-low):
  - loadseed_OutLow = 1, loadrand_OutLow = 1, grant = 00, valid = 0, data_OutBUS = 0, busy = 0.
  - State IDLE, round-robin pointer = requester 0, stir counter = 0, seed_pending = 0, seed edge register = 1.
  - Reset mid-operation aborts the transaction immediately; no strobe completes.
- Seed edge detection:
  - A 1→0 transition on seedreq sets seed_pending.
  - Holding seedreq low produces exactly one pulse.
- Stir counter:
  - Increments every cycle and saturates at STIR_CYCLES.
  - Cleared in SEED and CAPTURE.
- IDLE:
  - seed_pending has priority over requests → SEED.
  - Otherwise, if any req bit is set → grant the pointer's requester if it is requesting, else the other one; latch the grant and go to STIR.
- STIR: wait until the counter equals STIR_CYCLES, then → CAPTURE. If the condition already holds on entry, spend exactly one cycle here.
- SEED: loadseed_OutLow = 0 for exactly one cycle; clear seed_pending → IDLE.
- CAPTURE: loadrand_OutLow = 0 for exactly one cycle → WAITREG.
- WAITREG: the register output is now updated; capture data_InBUS into data_OutBUS on this cycle's clock edge → DELIVER.
- DELIVER:
  - valid = 1 and grant held while req[granted] = 1.
  - When req[granted] = 0, valid drops that cycle (combinational on state and req), state → IDLE, and the pointer moves to the other requester.
  - If req was already dropped before DELIVER, valid is high for exactly one cycle.
- Latency: from req seen in IDLE with the stir counter saturated, CAPTURE strobe at +2, valid at +4.
- Seed edge arriving in STIR/CAPTURE/WAITREG/DELIVER: held pending and serviced on the next IDLE, before any waiting request.
- Both requests set with pointer = 0: requester 0 is served first, then requester 1.
- Strobes are never asserted simultaneously. Grant is always one-hot or zero.
- data_OutBUS holds its last value outside DELIVER.

Decomposition:
- Package sc_rng_pkg: state enum (IDLE, SEED, STIR, CAPTURE, WAITREG, DELIVER), requester count constant 2, stir counter width function.
- One sub-module: sc_rng_rr_arbiter2 (combinational two-way round-robin pick plus registered pointer update on a completion pulse).
- Edge detector and FSM stay inline.

Test Plan:
- Reset assertion in DELIVER with valid = 1 → all outputs at reset values asynchronously, before the next clock edge.
- After reset, idle 10 cycles, req = 01, data_InBUS = 0xA5 from WAITREG onward → loadrand low only at cycle +2, grant = 01, valid at +4 with data 0xA5, valid = 0 in the same cycle req drops.
- req0 held for two back-to-back transactions → second loadrand pulse ≥ 8 cycles after the first; data updated to the new value (e.g. 0x3C).
- req = 11 held continuously → grant sequence 01, 10, 01, with each grant released only after its req drops.
- seedreq falls during DELIVER while req1 is pending → after req0 drops: IDLE, SEED (one loadseed low cycle), IDLE, then grant = 10 and capture ≥ 8 cycles after the seed pulse.
- seedreq held low for 20 cycles, then high → exactly one loadseed pulse and no loadrand activity.
